// File: rtl/fc_layer5_if.sv
// fc_layer5_if: bus between the layer-5 FC stage and its controller / memories
// Signals:
//   L5_en                  stage enable from the top controller
//   L4_output_read_addr    L4 feature read address
//   L4_output_read_data    L4 feature data (MEM_LATENCY cycles after address)
//   L5_weight_addr         weight/bias read address
//   L5_weight_dout         weight/bias data (same latency)
//   L5_output_write_addr   neuron index written
//   L5_output_write_data   neuron result
//   L5_output_wea          write strobe, one cycle per neuron
//   neuron_count           current neuron index
//   L5_done                high while the layer is complete
// Modports: master = FC stage, slave = controller/memory side.
interface fc_layer5_if #(parameter int DATA_WIDTH = 16);
   logic                  L5_en;
   logic [8:0]            L4_output_read_addr;
   logic [DATA_WIDTH-1:0] L4_output_read_data;
   logic [15:0]           L5_weight_addr;
   logic [DATA_WIDTH-1:0] L5_weight_dout;
   logic [6:0]            L5_output_write_addr;
   logic [DATA_WIDTH-1:0] L5_output_write_data;
   logic                  L5_output_wea;
   logic [6:0]            neuron_count;
   logic                  L5_done;
   modport master (
      input  L5_en, L4_output_read_data, L5_weight_dout,
      output L4_output_read_addr, L5_weight_addr, L5_output_write_addr,
             L5_output_write_data, L5_output_wea, neuron_count, L5_done
   );
   modport slave (
      output L5_en, L4_output_read_data, L5_weight_dout,
      input  L4_output_read_addr, L5_weight_addr, L5_output_write_addr,
             L5_output_write_data, L5_output_wea, neuron_count, L5_done
   );
endinterface

// File: rtl/fc_layer5_wrapper.sv
// fc_layer5_wrapper: fully-connected layer 5, one neuron at a time through a single signed MAC
// Ports:
//   clk  clock
//   rst  synchronous reset, active-low
//   bus  fc_layer5_if.master (enable, L4 feature read, weight read, L5 result write, status)
// Optional feature macro FC_RELU_EN: when defined, negative results are written as 0.
module fc_layer5_wrapper #(
   parameter int DATA_WIDTH  = 16,
   parameter int FRAC_BITS   = 8,
   parameter int IN_SIZE     = 400,
   parameter int OUT_SIZE    = 120,
   parameter int MEM_LATENCY = 2,
   parameter int ACC_WIDTH   = 41
) (
   input logic       clk,
   input logic       rst,
   fc_layer5_if.master bus
);
   localparam int DCW = $clog2(MEM_LATENCY + 1);
   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_RUN   = 5'b00010,
      S_DRAIN = 5'b00100,
      S_WRITE = 5'b01000,
      S_DONE  = 5'b10000
   } state_t;
   state_t r_state, w_next;
   logic [8:0]                  r_idx;
   logic [15:0]                 r_base;
   logic [6:0]                  r_n, r_waddr;
   logic [DCW-1:0]              r_dcnt;
   logic [MEM_LATENCY-1:0]      r_vld, r_bias;
   logic signed [ACC_WIDTH-1:0] r_acc, w_add, w_sum, w_shift;
   logic signed [2*DATA_WIDTH-1:0] w_prod;
   logic [ACC_WIDTH-DATA_WIDTH:0] w_hi;
   logic [DATA_WIDTH-1:0]       r_wdata, w_sat, w_res;
   logic w_en, w_idx_last, w_drain_last, w_n_last;
   assign w_en         = bus.L5_en;
   assign w_idx_last   = r_idx == 9'(IN_SIZE);
   assign w_drain_last = r_dcnt == DCW'(MEM_LATENCY - 1);
   assign w_n_last     = r_n == 7'(OUT_SIZE - 1);
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_en ? S_RUN : S_IDLE;
         S_RUN:   w_next = !w_en ? S_IDLE : w_idx_last ? S_DRAIN : S_RUN;
         S_DRAIN: w_next = !w_en ? S_IDLE : w_drain_last ? S_WRITE : S_DRAIN;
         S_WRITE: w_next = !w_en ? S_IDLE : w_n_last ? S_DONE : S_RUN;
         S_DONE:  w_next = w_en ? S_DONE : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   // The oldest pipeline slot holds the word returning from memory this cycle.
   assign w_prod  = $signed(bus.L4_output_read_data) * $signed(bus.L5_weight_dout);
   assign w_add   = !r_vld[MEM_LATENCY-1] ? '0 :
                    r_bias[MEM_LATENCY-1] ? ACC_WIDTH'($signed(bus.L5_weight_dout)) <<< FRAC_BITS :
                    ACC_WIDTH'(w_prod);
   assign w_sum   = r_acc + w_add;
   assign w_shift = w_sum >>> FRAC_BITS;
   // In range only when every bit above the result's sign bit matches it.
   assign w_hi    = w_shift[ACC_WIDTH-1:DATA_WIDTH-1];
   assign w_sat   = (&w_hi || ~|w_hi) ? w_shift[DATA_WIDTH-1:0] :
                    {w_hi[ACC_WIDTH-DATA_WIDTH], {(DATA_WIDTH-1){~w_hi[ACC_WIDTH-DATA_WIDTH]}}};
`ifdef FC_RELU_EN
   assign w_res   = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
   assign w_res   = w_sat;
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_base  <= '0;
         r_n     <= '0;
         r_dcnt  <= '0;
         r_vld   <= '0;
         r_bias  <= '0;
         r_acc   <= '0;
         r_wdata <= '0;
         r_waddr <= '0;
      end else begin
         r_state <= w_next;
         // idx parks on the bias index through DRAIN, otherwise restarts at 0
         r_idx   <= (r_state == S_RUN && w_next == S_RUN) ? r_idx + 9'd1 :
                    (w_next == S_DRAIN) ? r_idx : '0;
         r_dcnt  <= (r_state == S_DRAIN && w_next == S_DRAIN) ? r_dcnt + DCW'(1) : '0;
         r_n     <= (r_state == S_WRITE && w_next == S_RUN) ? r_n + 7'd1 :
                    (w_next == S_IDLE) ? '0 : r_n;
         r_base  <= (r_state == S_WRITE && w_next == S_RUN) ? r_base + 16'(IN_SIZE + 1) :
                    (w_next == S_IDLE) ? '0 : r_base;
         r_vld   <= (w_next == S_IDLE) ? '0 : (r_vld << 1) | MEM_LATENCY'(r_state == S_RUN);
         r_bias  <= (w_next == S_IDLE) ? '0 : (r_bias << 1) | MEM_LATENCY'(r_state == S_RUN && w_idx_last);
         r_acc   <= (w_next == S_RUN || w_next == S_DRAIN) ? w_sum : '0;
         // The bias lands on the last DRAIN cycle, so the result is taken from the live sum.
         if (r_state == S_DRAIN && w_next == S_WRITE) begin
            r_wdata <= w_res;
            r_waddr <= r_n;
         end
      end
   end
   assign bus.L4_output_read_addr  = w_idx_last ? 9'(IN_SIZE - 1) : r_idx;
   assign bus.L5_weight_addr       = r_base + 16'(r_idx);
   assign bus.L5_output_write_addr = r_waddr;
   assign bus.L5_output_write_data = r_wdata;
   assign bus.L5_output_wea        = (r_state == S_WRITE) && w_en;
   assign bus.neuron_count         = r_n;
   assign bus.L5_done              = r_state == S_DONE;
endmodule

// File: tb/tb_fc_layer5_wrapper.sv
// tb_fc_layer5_wrapper: scoreboard bench for fc_layer5_wrapper with latency-2 memory models
module tb_fc_layer5_wrapper;
   typedef struct {
      logic [6:0]  a;
      logic [15:0] d;
      int          t;
   } exp_t;
   logic clk = 1'b0;
   logic rst, en;
   logic [15:0] l4_v, w_v, bias_v, sp_b;
   logic [15:0] l4_d1, l4_q, w_d1, w_q;
   int sp_n, cyc = 0, t0, checks = 0, fails = 0;
   bit saw_2405 = 1'b0;
   exp_t q[$];
   exp_t e;
   fc_layer5_if #(.DATA_WIDTH(16)) bus();
   fc_layer5_wrapper dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign bus.L5_en = en;
   assign bus.L4_output_read_data = l4_q;
   assign bus.L5_weight_dout = w_q;
   function automatic logic [15:0] wfn(input logic [15:0] a);
      int i, n;
      i = int'(a) % 401;
      n = int'(a) / 401;
      if (i == 400) return (n == sp_n) ? sp_b : bias_v;
      return w_v;
   endfunction
   always @(posedge clk) begin
      cyc <= cyc + 1;
      l4_d1 <= l4_v;
      l4_q <= l4_d1;
      w_d1 <= wfn(bus.L5_weight_addr);
      w_q <= w_d1;
   end
   always @(negedge clk) begin
      if (bus.L5_weight_addr == 16'd2405) saw_2405 = 1'b1;
      if (bus.L5_output_wea) begin
         checks++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_wea addr=%0d data=%h cyc=%0d", bus.L5_output_write_addr, bus.L5_output_write_data, cyc);
         end else begin
            e = q.pop_front();
            if (bus.L5_output_write_addr != e.a || bus.L5_output_write_data != e.d || cyc != e.t) begin
               fails++;
               $display("FAIL write_n%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                        e.a, bus.L5_output_write_addr, bus.L5_output_write_data, cyc, e.a, e.d, e.t);
            end
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", nm, act, want);
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_wea"}, 32'(bus.L5_output_wea), 0);
      chk({tag, "_done"}, 32'(bus.L5_done), 0);
      chk({tag, "_count"}, 32'(bus.neuron_count), 0);
      chk({tag, "_waddr"}, 32'(bus.L5_output_write_addr), 0);
      chk({tag, "_wdata"}, 32'(bus.L5_output_write_data), 0);
      chk({tag, "_l4addr"}, 32'(bus.L4_output_read_addr), 0);
      chk({tag, "_waddr_w"}, 32'(bus.L5_weight_addr), 0);
   endtask
   task automatic start();
      en = 1'b1;
      t0 = cyc + 1;
   endtask
   task automatic push(input int n, input logic [15:0] d);
      q.push_back('{7'(n), d, t0 + 404 * n + 403});
   endtask
   task automatic one_neuron(input string nm, input logic [15:0] w, input logic [15:0] want);
      w_v = w;
      @(negedge clk);
      start();
      push(0, want);
      repeat (504) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk({nm, "_q_empty"}, 32'(q.size()), 0);
   endtask
   initial begin
      rst = 1'b0; en = 1'b0;
      l4_v = 16'h0100; w_v = 16'h0001; bias_v = 16'h0000; sp_n = -1; sp_b = 16'h0000;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;
      @(negedge clk);
      start();
      for (int n = 0; n < 10; n++) push(n, 16'h0190);
      repeat (404 * 10 + 402) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_zero("rst_drain");
      repeat (3) @(negedge clk);
      chk("rst_drain_q_empty", 32'(q.size()), 0);
      en = 1'b0; rst = 1'b1;
      @(negedge clk);
      start();
      for (int n = 0; n < 120; n++) push(n, 16'h0190);
      repeat (120 * 404 + 1) @(negedge clk);
      chk("full_done", 32'(bus.L5_done), 1);
      chk("full_done_count", 32'(bus.neuron_count), 119);
      repeat (10) @(negedge clk);
      chk("full_done_hold", 32'(bus.L5_done), 1);
      chk("full_q_empty", 32'(q.size()), 0);
      en = 1'b0;
      @(negedge clk);
      chk("full_done_drop", 32'(bus.L5_done), 0);
      chk("full_count_drop", 32'(bus.neuron_count), 0);
`ifdef FC_RELU_EN
      one_neuron("neg", 16'hFFFF, 16'h0000);
      one_neuron("sat_lo", 16'hFF00, 16'h0000);
`else
      one_neuron("neg", 16'hFFFF, 16'hFE70);
      one_neuron("sat_lo", 16'hFF00, 16'h8000);
`endif
      one_neuron("sat_hi", 16'h0100, 16'h7FFF);
      w_v = 16'h0000; sp_n = 5; sp_b = 16'h0280; saw_2405 = 1'b0;
      @(negedge clk);
      start();
      for (int n = 0; n < 6; n++) push(n, (n == 5) ? 16'h0280 : 16'h0000);
      repeat (404 * 6 + 10) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("bias_q_empty", 32'(q.size()), 0);
      chk("bias_addr_2405", 32'(saw_2405), 1);
      chk("hold_waddr", 32'(bus.L5_output_write_addr), 5);
      chk("hold_wdata", 32'(bus.L5_output_write_data), 32'h0280);
      sp_n = -1; w_v = 16'h0001;
      @(negedge clk);
      start();
      for (int n = 0; n < 3; n++) push(n, 16'h0190);
      repeat (404 * 3 + 200) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("drop_count", 32'(bus.neuron_count), 0);
      chk("drop_done", 32'(bus.L5_done), 0);
      chk("drop_wea", 32'(bus.L5_output_wea), 0);
      repeat (20) @(negedge clk);
      chk("drop_q_empty", 32'(q.size()), 0);
      start();
      push(0, 16'h0190);
      @(negedge clk);
      chk("restart_waddr0", 32'(bus.L5_weight_addr), 0);
      chk("restart_count0", 32'(bus.neuron_count), 0);
      @(negedge clk);
      chk("restart_waddr1", 32'(bus.L5_weight_addr), 1);
      repeat (403) @(negedge clk);
      chk("restart_count1", 32'(bus.neuron_count), 1);
      chk("restart_base", 32'(bus.L5_weight_addr), 401);
      repeat (50) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("restart_q_empty", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/fc_layer5_wrapper.md
Name: fc_layer5_wrapper

Overview:
Fully-connected stage directly downstream of the layer-3 conv / layer-4 pool block. Once L4 pooled features are complete, it reads the flattened 400-word L4 output memory. It computes OUT_SIZE neurons, one at a time, with a single pipelined signed MAC. Each result is biased, rescaled, saturated and written to the L5 output block memory.

Parameters:
DATA_WIDTH, 16, word width; signed fixed point Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
FRAC_BITS, 8, fractional bits of activations, weights and bias
IN_SIZE, 400, inputs per neuron (16 ch x 5 x 5 flattened)
OUT_SIZE, 120, neuron count
MEM_LATENCY, 2, block-memory read latency in cycles (address to data)
ACC_WIDTH, 41, accumulator width (2*DATA_WIDTH + 9; no overflow for IN_SIZE products)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
L5_en  in  1  stage enable; held high by top controller for the whole layer
L4_output_read_addr  out  9  L4 feature read address (0..IN_SIZE-1)
L4_output_read_data  in  DATA_WIDTH  L4 feature data, valid MEM_LATENCY cycles after address
L5_weight_addr  out  16  weight/bias read address
L5_weight_dout  in  DATA_WIDTH  weight/bias data, same latency
L5_output_write_addr  out  7  neuron index written
L5_output_write_data  out  DATA_WIDTH  neuron result
L5_output_wea  out  1  write strobe, one cycle per neuron
neuron_count  out  7  current neuron index
L5_done  out  1  high while in DONE

Behaviour:
- Weight layout is neuron-major, IN_SIZE+1 words per neuron; the last word is the bias. Address = n*(IN_SIZE+1) + idx. It is kept as a running base register plus idx, with no multiplier.
- All outputs reset to 0 when rst==0. Reset mid-operation forces IDLE, clears the accumulator and pipeline valids, and suppresses any pending write.
- Top FSM (one-hot): IDLE -> RUN when L5_en=1.
- RUN: idx counts 0..IN_SIZE, one per cycle. L4 addr = idx for idx<IN_SIZE; L4 addr is held at IN_SIZE-1 during the bias fetch. When idx==IN_SIZE -> DRAIN.
- DRAIN: lasts MEM_LATENCY cycles, then -> WRITE.
- WRITE: exactly one cycle. If neuron_count==OUT_SIZE-1 -> DONE; else neuron_count+1, weight base += IN_SIZE+1, idx=0, acc=0, -> RUN.
- DONE: stays while L5_en=1; returns to IDLE when L5_en=0. On leaving DONE, neuron_count and the base return to 0.
- L5_en=0 in RUN/DRAIN/WRITE: next state is IDLE, the current neuron is discarded with no wea, and counters clear.
- Pipeline: a MEM_LATENCY-deep valid/is_bias shift register tags each issued read.
  - Valid input word: acc += sign-extended (data * weight), a full 2*DATA_WIDTH product.
  - Bias word: acc += bias <<< FRAC_BITS.
- WRITE data:
  - Step 1: arithmetic shift acc >>> FRAC_BITS, truncating toward -inf.
  - Step 2: saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then apply the optional ReLU.
  - Write addr = neuron_count.
- Timing per neuron: IN_SIZE+1+MEM_LATENCY+1 = 404 cycles. The first wea is asserted on the 404th cycle after RUN entry. L5_done rises the cycle after the last WRITE (120*404 cycles after RUN entry).
- write_data and write_addr hold their last values between strobes.

Optional Feature:
FC_RELU_EN
- Defined: negative saturated results are written as 0 (hidden-layer ReLU).
- Undefined: the signed saturated value is written unchanged (used for the final logits layer).

Test Plan:
- All L4=0x0100, all weights=0x0001, bias=0 -> every neuron writes 0x0190. The first wea is 404 cycles after RUN entry; 120 strobes total at addrs 0..119. L5_done then stays high until L5_en drops.
- Weights=0xFFFF, L4=0x0100, bias 0 -> 0x0000 with FC_RELU_EN; 0xFE70 without it.
- Weights=0x0100, L4=0x0100 -> true sum 400.0 saturates to 0x7FFF. Same case with weights=0xFF00 -> 0x8000 without FC_RELU_EN.
- Weights=0, bias=0x0280 for neuron 5 only -> addr 5 writes 0x0280 and all other addrs write 0. Confirms bias address 5*401+400=2405 is read.
- Drop L5_en at neuron 3, mid-RUN -> IDLE next cycle, no further wea. Re-raise L5_en -> restarts at neuron 0 with weight addr 0.
- Assert rst=0 during DRAIN of neuron 10 -> all outputs 0, no wea. After release, a full run matches the first scenario.
